// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core: one FSM walks FETCH/DECODE/EXEC/MEM/WB
// around a shared ALU, with handshaked instruction and data memories.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          NUM_REGS    = 32,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        retire,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic        illegal
);

  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [4:0] HI_MASK = ~5'(NUM_REGS - 1);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t      state;
  logic [31:0] pc, ir, a_reg, b_reg, imm_reg, alu_out, mdr;
  logic [31:0] gpr [NUM_REGS];

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd;
  logic [RW-1:0] wb_idx;
  logic          op_legal, regs_legal, wb_en;
  logic [31:0]   alu_b, alu_y, wb_data, imm_sext;

  assign opcode   = ir[31:26];
  assign funct    = ir[5:0];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: op_legal = 1'b1;
          default: op_legal = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  end

  // Register fields must fit the configured file; j names no registers.
  assign regs_legal = (opcode == OP_J) ||
                      ((((rs | rt) & HI_MASK) == 5'd0) &&
                       (opcode != OP_R || (rd & HI_MASK) == 5'd0));

  always_comb begin
    alu_b = (opcode == OP_R) ? b_reg : imm_reg;
    alu_y = a_reg + alu_b;
    if (opcode == OP_R) begin
      case (funct)
        F_SUB:   alu_y = a_reg - alu_b;
        F_AND:   alu_y = a_reg & alu_b;
        F_OR:    alu_y = a_reg | alu_b;
        F_SLT:   alu_y = {31'd0, $signed(a_reg) < $signed(alu_b)};
        default: alu_y = a_reg + alu_b;
      endcase
    end
  end

  assign wb_idx  = (opcode == OP_R) ? ir[11 +: RW] : ir[16 +: RW];
  assign wb_data = (opcode == OP_LW) ? mdr : alu_out;
  assign wb_en   = (state == WB) && (wb_idx != '0);

  // Entry 0 is never written, so $0 reads zero without a read-side mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
    end else if (wb_en) begin
      gpr[wb_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      imm_reg <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          ir    <= imem_rdata;
          pc    <= pc + 32'd4;
          state <= DECODE;
        end
        DECODE: begin
          a_reg   <= gpr[ir[21 +: RW]];
          b_reg   <= gpr[ir[16 +: RW]];
          imm_reg <= imm_sext;
          state   <= (op_legal && regs_legal) ? EXEC : HALT;
        end
        // j resolves here alongside beq so both retire in the third cycle.
        EXEC: begin
          case (opcode)
            OP_J: begin
              pc    <= {pc[31:28], ir[25:0], 2'b00};
              state <= FETCH;
            end
            OP_BEQ: begin
              if (a_reg == b_reg) pc <= pc + {imm_reg[29:0], 2'b00};
              state <= FETCH;
            end
            OP_LW, OP_SW: begin
              alu_out <= alu_y;
              state   <= (ALIGN_CHECK && alu_y[1:0] != 2'b00) ? HALT : MEM;
            end
            default: begin
              alu_out <= alu_y;
              state   <= WB;
            end
          endcase
        end
        MEM: if (dmem_ready) begin
          mdr   <= dmem_rdata;
          state <= (opcode == OP_SW) ? FETCH : WB;
        end
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

  // Gating with rst lets the fetch request drop during reset and rise
  // in the very first cycle after release.
  assign imem_req   = (state == FETCH) && rst;
  assign imem_addr  = pc;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = (state == MEM) && (opcode == OP_SW);
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b_reg;
  assign retire     = (state == WB) ||
                      (state == EXEC && (opcode == OP_J || opcode == OP_BEQ)) ||
                      (state == MEM && dmem_ready && opcode == OP_SW);
  assign pc_out     = pc;
  assign halted     = (state == HALT);
  assign illegal    = (state == HALT);

endmodule
